// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-select adder.
//   DEFAULT_WIDTH / DEFAULT_BLK : default operand width and carry-select block size
//   nblocks(width, blk)         : number of carry-select blocks, ceil(width / blk)
package csa_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_BLK   = 2;

  function automatic int nblocks(input int width, input int blk);
    return (width + blk - 1) / blk;
  endfunction

endpackage

// File: rtl/rca_block.sv
// Ripple-carry adder slice used as the building block of the carry-select adder.
//   a, b : W-bit operand slices
//   ci   : carry in
//   s    : W-bit sum slice
//   co   : carry out of the slice's top bit
module rca_block #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  // c[i] is the carry into bit i; c[W] leaves the slice.
  logic [W:0] c;

  // NOTE: combinational blocks use blocking '=' and assign every output first,
  // so the chain evaluates in order and no latch can be inferred.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[W];
  end

endmodule

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: {cout, sum} = a + b + cin, one cycle of latency.
// Block 0 ripples from cin; each higher block computes its slice for both carry-in
// values and the carry out of the block below picks one. The last block is narrower
// when BLK does not divide WIDTH.
//   clk   : clock, results captured on the rising edge
//   rst_n : asynchronous active-low clear of sum/cout
//   a, b  : WIDTH-bit unsigned operands
//   cin   : carry in
//   sum   : registered WIDTH-bit sum
//   cout  : registered carry out of bit WIDTH-1
module carry_select_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLK   = DEFAULT_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NB = nblocks(WIDTH, BLK);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  for (genvar k = 0; k < NB; k++) begin : blk_g
    localparam int LO = k * BLK;
    localparam int HI = ((k + 1) * BLK > WIDTH) ? WIDTH - 1 : (k + 1) * BLK - 1;
    localparam int BW = HI - LO + 1;

    // Selected carry out of this block; feeds the select of block k+1.
    logic co;

    if (k == 0) begin : rip_g
      rca_block #(.W(BW)) u_rca (
        .a  (a[HI:LO]),
        .b  (b[HI:LO]),
        .ci (cin),
        .s  (sum_c[HI:LO]),
        .co (co)
      );
    end else begin : sel_g
      logic [BW-1:0] s0, s1;
      logic          co0, co1;

      rca_block #(.W(BW)) u_rca0 (
        .a  (a[HI:LO]),
        .b  (b[HI:LO]),
        .ci (1'b0),
        .s  (s0),
        .co (co0)
      );

      rca_block #(.W(BW)) u_rca1 (
        .a  (a[HI:LO]),
        .b  (b[HI:LO]),
        .ci (1'b1),
        .s  (s1),
        .co (co1)
      );

      assign sum_c[HI:LO] = blk_g[k-1].co ? s1  : s0;
      assign co           = blk_g[k-1].co ? co1 : co0;
    end
  end

  always_comb begin
    sum_d  = sum_c;
    cout_d = blk_g[NB-1].co;
  end

  // NOTE: clocked state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Scoreboard bench for carry_select_adder: a WIDTH=4/BLK=2 instance (directed cases,
// exhaustive sweep, mid-stream reset) runs alongside a WIDTH=7/BLK=3 instance fed
// random vectors. Expected results are plain integer sums queued at capture time and
// compared by an independent monitor on the falling edge.
module tb_carry_select_adder;

  logic       clk;
  logic       rst_n;
  logic [3:0] a4, b4, sum4;
  logic       cin4, cout4;
  logic [6:0] a7, b7, sum7;
  logic       cin7, cout7;

  int checks;
  int errors;

  int exp4_q[$];
  int exp7_q[$];

  carry_select_adder #(.WIDTH(4), .BLK(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .sum   (sum4),
    .cout  (cout4)
  );

  carry_select_adder #(.WIDTH(7), .BLK(3)) dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a7),
    .b     (b7),
    .cin   (cin7),
    .sum   (sum7),
    .cout  (cout7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every falling edge, compare the result captured on the preceding
  // rising edge with whatever the driver queued for it.
  initial begin
    forever begin
      @(negedge clk);
      if (exp4_q.size() > 0) check("sum4", int'({cout4, sum4}), exp4_q.pop_front());
      if (exp7_q.size() > 0) check("sum7", int'({cout7, sum7}), exp7_q.pop_front());
    end
  end

  // Apply one vector to each DUT, let the rising edge capture it, then queue the
  // arithmetic result for the monitor.
  task automatic drive(input logic [3:0] x4, input logic [3:0] y4, input logic c4,
                       input logic [6:0] x7, input logic [6:0] y7, input logic c7);
    a4 = x4; b4 = y4; cin4 = c4;
    a7 = x7; b7 = y7; cin7 = c7;
    @(posedge clk);
    #1;
    exp4_q.push_back(int'(x4) + int'(y4) + int'(c4));
    exp7_q.push_back(int'(x7) + int'(y7) + int'(c7));
  endtask

  task automatic drive_rand7(input logic [3:0] x4, input logic [3:0] y4, input logic c4);
    drive(x4, y4, c4, 7'($urandom), 7'($urandom), 1'($urandom));
  endtask

  initial begin
    logic [8:0] v;
    int         budget;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a7 = '0; b7 = '0; cin7 = 1'b0;

    #2;
    check("reset_out4", int'({cout4, sum4}), 0);
    check("reset_out7", int'({cout7, sum7}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including the block-boundary and full-propagation corners.
    drive_rand7(4'b0001, 4'b0010, 1'b0);
    drive_rand7(4'b1010, 4'b0110, 1'b0);
    drive_rand7(4'b0111, 4'b1101, 1'b1);
    drive_rand7(4'b0000, 4'b0000, 1'b0);
    drive(4'b1111, 4'b0000, 1'b1, 7'h7f, 7'h00, 1'b1);
    drive(4'b1111, 4'b1111, 1'b1, 7'h7f, 7'h7f, 1'b1);

    // Mid-stream reset with the all-ones case still on the inputs.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear4", int'({cout4, sum4}), 0);
    check("async_clear7", int'({cout7, sum7}), 0);
    @(posedge clk);
    #1;
    check("held_clear4", int'({cout4, sum4}), 0);
    check("held_clear7", int'({cout7, sum7}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, 7'h55, 7'h2b, 1'b0);

    // Exhaustive sweep of the 4-bit instance, back-to-back one per cycle.
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      drive_rand7(v[8:5], v[4:1], v[0]);
    end

    // Drain: the monitor must consume every queued expectation within a few cycles.
    budget = 0;
    while ((exp4_q.size() > 0 || exp7_q.size() > 0) && budget < 5) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    #1;
    check("drain4", exp4_q.size(), 0);
    check("drain7", exp7_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
